// File: rtl/vgafb_fmlfetch.sv
// Framebuffer fetch: FML 4-beat bursts into a word FIFO, unpacked to an RGB565 pixel stream.
// Define VGAFB_FMLFETCH_LE_EN to emit the low half-word of each FIFO word first.
`timescale 1ns/1ps
module vgafb_fmlfetch #(
    parameter int unsigned fifo_depth_log2 = 5
) (
    input  logic        sys_clk,
    input  logic        vga_rst,
    input  logic [31:0] baseaddress,
    output logic        baseaddress_ack,
    input  logic [18:0] nbursts,
    output logic [31:0] fml_adr,
    output logic        fml_stb,
    input  logic        fml_ack,
    input  logic [31:0] fml_di,
    output logic        pixel_valid,
    output logic [15:0] pixel,
    input  logic        pixel_ack
);

    localparam int unsigned AW = fifo_depth_log2;
    localparam int unsigned Depth = 1 << AW;
    // Highest occupancy that still leaves room for a full burst.
    localparam logic [AW:0] MaxFill = (AW + 1)'(Depth - 4);

    typedef enum logic [1:0] {StStart, StReq, StData} state_e;

    state_e        state_q;
    logic [18:0]   bcnt_q;
    logic [18:0]   nlast_q;
    logic [1:0]    beat_q;

    logic [31:0]   mem_q [Depth];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          half_q;
    logic          wr_en;
    logic          rd_en;
    logic          take;
    logic [31:0]   head;

    assign wr_en       = (state_q == StData);
    assign pixel_valid = (count_q != '0);
    assign take        = pixel_valid && pixel_ack;
    assign rd_en       = take && half_q;
    assign head        = mem_q[rd_ptr_q];

`ifdef VGAFB_FMLFETCH_LE_EN
    assign pixel = half_q ? head[31:16] : head[15:0];
`else
    assign pixel = half_q ? head[15:0] : head[31:16];
`endif

    always_ff @(posedge sys_clk or posedge vga_rst) begin
        if (vga_rst) begin
            state_q         <= StStart;
            fml_stb         <= 1'b0;
            fml_adr         <= 32'd0;
            baseaddress_ack <= 1'b0;
            bcnt_q          <= 19'd0;
            nlast_q         <= 19'd0;
            beat_q          <= 2'd0;
        end else begin
            baseaddress_ack <= 1'b0;
            unique case (state_q)
                StStart: begin
                    fml_adr         <= {baseaddress[31:4], 4'h0};
                    bcnt_q          <= 19'd0;
                    nlast_q         <= (nbursts == 19'd0) ? 19'd0 : nbursts - 19'd1;
                    baseaddress_ack <= 1'b1;
                    state_q         <= StReq;
                end
                StReq: begin
                    // Once raised, the strobe is held until accepted.
                    if (fml_stb) begin
                        if (fml_ack) begin
                            fml_stb <= 1'b0;
                            beat_q  <= 2'd0;
                            state_q <= StData;
                        end
                    end else if (count_q <= MaxFill) begin
                        fml_stb <= 1'b1;
                    end
                end
                StData: begin
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        if (bcnt_q == nlast_q) begin
                            state_q <= StStart;
                        end else begin
                            bcnt_q  <= bcnt_q + 19'd1;
                            fml_adr <= fml_adr + 32'd16;
                            state_q <= StReq;
                        end
                    end
                end
                default: state_q <= StStart;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge vga_rst) begin
        if (vga_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            half_q   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (take) half_q <= ~half_q;
            if (wr_en && !rd_en) count_q <= count_q + (AW + 1)'(1);
            else if (!wr_en && rd_en) count_q <= count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= fml_di;
    end

endmodule
